// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch unit with a small PC-tagged word queue (optional IFETCH_STATS_EN counters)
module ifetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        mem_read,
    output logic [15:0] mem_address,
    input  logic        mem_resp,
    input  logic [15:0] mem_rdata,
    output logic        ir_valid,
    output logic [15:0] ir_data,
    output logic [15:0] ir_pc,
`ifdef IFETCH_STATS_EN
    output logic [15:0] stat_fetch_count,
    output logic [15:0] stat_discard_count,
`endif
    input  logic        ir_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DISCARD
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    fetch_pc_q, fetch_pc_d;
    logic           mem_read_q, mem_read_d;
    logic [15:0]    mem_address_q, mem_address_d;
    logic [15:0]    q_data [DEPTH];
    logic [15:0]    q_pc   [DEPTH];
    logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  count_after_pop;
    logic           pop, push, drop, slot_free;
    logic [15:0]    redirect_target;

    assign ir_valid        = (count_q != '0);
    assign pop             = ir_valid & ir_ready;
    assign count_after_pop = count_q - CW'(pop);
    assign slot_free       = (count_after_pop < CW'(DEPTH));
    assign redirect_target = redirect_pc & 16'hFFFE;

    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;
    assign ir_data     = ir_valid ? q_data[rd_ptr_q] : 16'h0000;
    assign ir_pc       = ir_valid ? q_pc[rd_ptr_q]   : 16'h0000;

    // Next-state, request and push/drop decisions
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        push          = 1'b0;
        drop          = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end else if (slot_free) begin
                    state_d       = S_FETCH;
                    mem_read_d    = 1'b1;
                    mem_address_d = fetch_pc_q;
                end
            end
            S_FETCH: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                    if (mem_resp) begin
                        state_d    = S_IDLE;
                        mem_read_d = 1'b0;
                        drop       = 1'b1;
                    end else begin
                        state_d = S_DISCARD;
                    end
                end else if (mem_resp) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 16'd2;
                    state_d    = S_IDLE;
                    mem_read_d = 1'b0;
                end
            end
            S_DISCARD: begin
                if (redirect) begin
                    fetch_pc_d = redirect_target;
                end
                if (mem_resp) begin
                    state_d    = S_IDLE;
                    mem_read_d = 1'b0;
                    drop       = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    // Fetch FSM state, PC and registered memory request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            fetch_pc_q    <= RESET_PC;
            mem_read_q    <= 1'b0;
            mem_address_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
        end
    end

    // Queue pointers and occupancy; a redirect flushes everything
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Queue storage: the word is tagged with the address it was read from
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr_q] <= mem_rdata;
            q_pc[wr_ptr_q]   <= mem_address_q;
        end
    end

`ifdef IFETCH_STATS_EN
    // Saturating counters of pushed words and redirect-dropped responses
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetch_count   <= 16'h0000;
            stat_discard_count <= 16'h0000;
        end else begin
            if (push && stat_fetch_count != 16'hFFFF)
                stat_fetch_count <= stat_fetch_count + 16'd1;
            if (drop && stat_discard_count != 16'hFFFF)
                stat_discard_count <= stat_discard_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed cycle-by-cycle bench for ifetch_queue
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        mem_read;
    logic [15:0] mem_address;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready;
`ifdef IFETCH_STATS_EN
    logic [15:0] stat_fetch_count;
    logic [15:0] stat_discard_count;
`endif

    int checks = 0;
    int errors = 0;

    ifetch_queue #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_read    (mem_read),
        .mem_address (mem_address),
        .mem_resp    (mem_resp),
        .mem_rdata   (mem_rdata),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
`ifdef IFETCH_STATS_EN
        .stat_fetch_count   (stat_fetch_count),
        .stat_discard_count (stat_discard_count),
`endif
        .ir_ready    (ir_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [15:0] rpc;
        logic        rsp;
        logic [15:0] rdat;
        logic        rdy;
        logic        emr;
        logic [15:0] ema;
        logic        eiv;
        logic [15:0] eid;
        logic [15:0] eip;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare outputs just after the edge
    task automatic step(input string name, input vec_t v);
        redirect    = v.rd;
        redirect_pc = v.rpc;
        mem_resp    = v.rsp;
        mem_rdata   = v.rdat;
        ir_ready    = v.rdy;
        @(posedge clk);
        #1;
        chk({name, ".mem_read"},    {15'h0, mem_read}, {15'h0, v.emr});
        chk({name, ".mem_address"}, mem_address,       v.ema);
        chk({name, ".ir_valid"},    {15'h0, ir_valid}, {15'h0, v.eiv});
        if (v.eiv) begin
            chk({name, ".ir_data"}, ir_data, v.eid);
            chk({name, ".ir_pc"},   ir_pc,   v.eip);
        end
    endtask

    initial begin
        // rd  rpc  rsp rdat  rdy   emr ema  eiv eid  eip
        tbl[0]  = '{0, 0, 0, 16'h0000, 1,  1, 16'h0000, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 16'h0000, 1,  1, 16'h0000, 0, 0, 0};
        tbl[2]  = '{0, 0, 1, 16'hA000, 1,  0, 16'h0000, 1, 16'hA000, 16'h0000};
        tbl[3]  = '{0, 0, 0, 16'h0000, 1,  1, 16'h0002, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 16'h0000, 1,  1, 16'h0002, 0, 0, 0};
        tbl[5]  = '{0, 0, 1, 16'hA002, 1,  0, 16'h0002, 1, 16'hA002, 16'h0002};
        tbl[6]  = '{0, 0, 0, 16'h0000, 1,  1, 16'h0004, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 16'h0000, 1,  1, 16'h0004, 0, 0, 0};
        tbl[8]  = '{0, 0, 1, 16'hA004, 1,  0, 16'h0004, 1, 16'hA004, 16'h0004};
        tbl[9]  = '{0, 0, 0, 16'h0000, 0,  1, 16'h0006, 1, 16'hA004, 16'h0004};
        tbl[10] = '{0, 0, 0, 16'h0000, 0,  1, 16'h0006, 1, 16'hA004, 16'h0004};
        tbl[11] = '{0, 0, 1, 16'hA006, 0,  0, 16'h0006, 1, 16'hA004, 16'h0004};
        tbl[12] = '{0, 0, 0, 16'h0000, 0,  0, 16'h0006, 1, 16'hA004, 16'h0004};
        tbl[13] = '{0, 0, 0, 16'h0000, 0,  0, 16'h0006, 1, 16'hA004, 16'h0004};
        tbl[14] = '{0, 0, 0, 16'h0000, 1,  1, 16'h0008, 1, 16'hA006, 16'h0006};
        tbl[15] = '{0, 0, 0, 16'h0000, 0,  1, 16'h0008, 1, 16'hA006, 16'h0006};
        tbl[16] = '{0, 0, 1, 16'hA008, 0,  0, 16'h0008, 1, 16'hA006, 16'h0006};
        tbl[17] = '{0, 0, 0, 16'h0000, 0,  0, 16'h0008, 1, 16'hA006, 16'h0006};
        tbl[18] = '{0, 0, 0, 16'h0000, 1,  1, 16'h000A, 1, 16'hA008, 16'h0008};
        tbl[19] = '{0, 0, 0, 16'h0000, 1,  1, 16'h000A, 0, 0, 0};

        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
        mem_resp = 1'b0; mem_rdata = 16'h0; ir_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.mem_read",    {15'h0, mem_read}, 16'h0000);
        chk("rst.mem_address", mem_address,       16'h0000);
        chk("rst.ir_valid",    {15'h0, ir_valid}, 16'h0000);
        chk("rst.ir_data",     ir_data,           16'h0000);
        chk("rst.ir_pc",       ir_pc,             16'h0000);
        reset = 1'b0;

        // Streaming fetch, then back-pressure with a full two-entry queue
        for (int i = 0; i < 20; i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Redirect while a read to 000A is outstanding: held, dropped, restart at 3000
        step("redir_hold",  '{1, 16'h3001, 0, 16'h0000, 1,  1, 16'h000A, 0, 0, 0});
        step("discard_wait",'{0, 16'h0000, 0, 16'h0000, 1,  1, 16'h000A, 0, 0, 0});
        step("discard_resp",'{0, 16'h0000, 1, 16'hDEAD, 1,  0, 16'h000A, 0, 0, 0});
        step("redir_issue", '{0, 16'h0000, 0, 16'h0000, 1,  1, 16'h3000, 0, 0, 0});
        step("redir_push",  '{0, 16'h0000, 1, 16'hBEEF, 0,  0, 16'h3000, 1, 16'hBEEF, 16'h3000});
        step("issue_3002",  '{0, 16'h0000, 0, 16'h0000, 0,  1, 16'h3002, 1, 16'hBEEF, 16'h3000});
        // Redirect coincident with the response and a pop: nothing pushed, queue flushed
        step("redir_resp",  '{1, 16'h5000, 1, 16'h1111, 1,  0, 16'h3002, 0, 0, 0});
        step("issue_5000",  '{0, 16'h0000, 0, 16'h0000, 1,  1, 16'h5000, 0, 0, 0});
        // PC wrap: redirect to FFFE, fetch it, then the next read goes to 0000
        step("redir_ffff",  '{1, 16'hFFFF, 0, 16'h0000, 1,  1, 16'h5000, 0, 0, 0});
        step("drop_5000",   '{0, 16'h0000, 1, 16'h9999, 1,  0, 16'h5000, 0, 0, 0});
        step("issue_fffe",  '{0, 16'h0000, 0, 16'h0000, 1,  1, 16'hFFFE, 0, 0, 0});
        step("push_fffe",   '{0, 16'h0000, 1, 16'h3333, 0,  0, 16'hFFFE, 1, 16'h3333, 16'hFFFE});
        step("wrap_issue",  '{0, 16'h0000, 0, 16'h0000, 1,  1, 16'h0000, 0, 0, 0});
        step("push_0000",   '{0, 16'h0000, 1, 16'h4444, 0,  0, 16'h0000, 1, 16'h4444, 16'h0000});
        step("issue_0002",  '{0, 16'h0000, 0, 16'h0000, 0,  1, 16'h0002, 1, 16'h4444, 16'h0000});

`ifdef IFETCH_STATS_EN
        chk("stat_fetch",   stat_fetch_count,   16'd8);
        chk("stat_discard", stat_discard_count, 16'd3);
`endif

        // Reset while a read is outstanding, then a stray response is ignored
        reset = 1'b1;
        step("rst_mid",     '{0, 16'h0000, 0, 16'h0000, 0,  0, 16'h0000, 0, 0, 0});
        chk("rst_mid.ir_data", ir_data, 16'h0000);
        chk("rst_mid.ir_pc",   ir_pc,   16'h0000);
`ifdef IFETCH_STATS_EN
        chk("rst_stat_fetch",   stat_fetch_count,   16'd0);
        chk("rst_stat_discard", stat_discard_count, 16'd0);
`endif
        reset = 1'b0;
        step("stray_resp",  '{0, 16'h0000, 1, 16'h7777, 1,  1, 16'h0000, 0, 0, 0});
        step("post_rst",    '{0, 16'h0000, 1, 16'h5555, 0,  0, 16'h0000, 1, 16'h5555, 16'h0000});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Instruction fetch stage directly upstream of the instruction register.
- Keeps the fetch PC and issues word reads to the instruction memory port using a hold-until-response handshake.
- Buffers returned instruction words with their PCs in a small FIFO and presents them to the IR load path through a valid/ready handshake.
- Handles control-flow redirects by flushing the queue and discarding any in-flight read.

Parameters:
- DEPTH, 2, number of queue entries; power of two, ≥2.
- RESET_PC, 16'h0000, fetch PC after reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address; bit 0 is ignored (forced to 0).
- mem_read  out  1  read request; held high until mem_resp.
- mem_address  out  16  byte address of the read; stable while mem_read is high.
- mem_resp  in  1  one-cycle pulse: read done, mem_rdata valid.
- mem_rdata  in  16  instruction word.
- ir_valid  out  1  head entry valid.
- ir_data  out  16  head instruction word, feeds the IR `in` input.
- ir_pc  out  16  PC of the head instruction.
- ir_ready  in  1  consumer asserts IR load; pop happens when ir_valid & ir_ready.

Behaviour:
- Reset (sync, active-high, overrides everything):
  - fetch_pc=RESET_PC; queue empty; state=IDLE.
  - mem_read=0, mem_address=RESET_PC, ir_valid=0, ir_data=0, ir_pc=0.
- States:
  - IDLE: no read outstanding.
  - FETCH: read outstanding.
  - DISCARD: read outstanding whose data will be dropped.
- Slot accounting: count = occupied entries. A read is issued only when count < DEPTH, with the pop of the current cycle taken into account.
- IDLE → FETCH:
  - Occurs when a slot is free and no redirect is present.
  - mem_read=1 and mem_address=fetch_pc, registered, so the request is visible the cycle after the decision.
- FETCH with mem_resp, no redirect:
  - Push {mem_rdata, mem_address} at that edge.
  - fetch_pc += 2, with 16-bit wrap: 16'hFFFE → 16'h0000.
  - mem_read drops for at least one cycle, then the next state is IDLE.
  - Back-to-back issue is not required; min fetch rate is 1 word per 2 + memory-latency cycles.
- Data visibility: a pushed word appears on ir_valid/ir_data the cycle after mem_resp. There is no combinational bypass from mem_rdata to ir_data.
- Pop: on ir_valid & ir_ready, the head advances at the edge. Push and pop in the same cycle keep count unchanged. Full queue never issues a read.
- Redirect:
  - Queue flushed (count=0, ir_valid=0 next cycle); fetch_pc=redirect_pc & 16'hFFFE.
  - IDLE: go to IDLE with the new PC; fetch issues the following cycle.
  - FETCH without mem_resp: go to DISCARD. mem_read and mem_address are held until mem_resp, then data is dropped and state returns to IDLE.
  - FETCH with mem_resp in the same cycle: the response is dropped, no push, state IDLE.
  - DISCARD: update fetch_pc, stay in DISCARD.
  - Redirect takes priority over a simultaneous pop and push. A pop in the redirect cycle is treated as consumed, with no error.
- mem_resp while in IDLE is ignored.
- Outputs ir_data and ir_pc are registered or read from the queue array. They hold their value while ir_valid=1 and ir_ready=0.
- Reset mid-operation: the in-flight read is abandoned and mem_read=0 next cycle. A late mem_resp after reset is ignored because state is IDLE.

Optional Feature:
- Macro: IFETCH_STATS_EN.
- When defined, add outputs:
  - stat_fetch_count (16): increments on every pushed word.
  - stat_discard_count (16): increments on every response dropped by redirect (DISCARD completion or same-cycle redirect+resp).
  - Both counters are cleared by reset and saturate at 16'hFFFF.
- When not defined, the ports and logic are absent and the rest of the behaviour is identical.

Test Plan:
- Reset with RESET_PC=16'h0000, memory responds after 2 cycles, ir_ready=1 → mem_address sequence 0000, 0002, 0004; ir_data matches memory; ir_pc=0000, 0002, 0004.
- ir_ready=0, DEPTH=2 → after 2 pushes mem_read stays 0 and ir_data/ir_pc stay stable. Raise ir_ready for one cycle → exactly one new read issued, to 0004.
- Redirect to 16'h3001 while a read to 0002 is outstanding → mem_address stays 0002 until mem_resp; that word is not pushed; next read goes to 3000; ir_valid=0 until it returns.
- Redirect coincident with mem_resp → no push; next mem_address=redirect_pc; discard counter +1 when IFETCH_STATS_EN is defined.
- fetch_pc at 16'hFFFE → push with ir_pc=FFFE, next read to 0000.
- Assert reset while mem_read=1 → next cycle mem_read=0, ir_valid=0, mem_address=RESET_PC; a stray mem_resp is ignored and there is no push.
